// File: rtl/trex_pkg.sv
// Shared types and encodings for the dino vertical-motion engine.
package trex_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_DUCK   = 2'b01,
        ST_AIR    = 2'b10,
        ST_DEAD   = 2'b11
    } dinoState_e;

    localparam logic [1:0] POSE_STAND = 2'b00;
    localparam logic [1:0] POSE_DUCK  = 2'b01;
    localparam logic [1:0] POSE_AIR   = 2'b10;
    localparam logic [1:0] POSE_DEAD  = 2'b11;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_RUN  = 2'b10;
    localparam logic [1:0] GS_DEAD = 2'b01;

    localparam int DEFAULT_GROUND_Y = 360;

    // Any encoding with the low bit set (01 or 11) means the game is over.
    function automatic logic isDead(input logic [1:0] gs);
        return (gs & GS_DEAD) != 2'b00;
    endfunction

endpackage

// File: rtl/rise_edge_pulse.sv
// Registered rising-edge detector: pulse is high while level is high and was low last cycle.
module rise_edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic levelPrev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            levelPrev <= 1'b0;
        end else begin
            levelPrev <= level;
        end
    end

    assign pulse = level & ~levelPrev;

endmodule

// File: rtl/dino_jump_physics.sv
// Dino vertical kinematics: per-frame velocity, gravity, landing and ceiling clamps.
// Optional macro TREX_VARIABLE_JUMP_EN: releasing jump early caps upward speed for a low hop.
module dino_jump_physics
    import trex_pkg::*;
#(
    parameter int GROUND_Y   = DEFAULT_GROUND_Y,
    parameter int JUMP_V0    = 14,
    parameter int GRAVITY    = 1,
    parameter int V_MAX_FALL = 20,
    parameter int MAX_H      = 200
`ifdef TREX_VARIABLE_JUMP_EN
    ,
    parameter int CUT_V      = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       jump,
    input  logic       duck,
    input  logic [1:0] game_state,
    output logic [8:0] dino_y,
    output logic [1:0] pose,
    output logic       airborne
);

    localparam logic [8:0]        GROUND_Y_U = 9'(GROUND_Y);
    localparam logic signed [6:0] JUMP_VEL   = 7'(JUMP_V0);
    localparam logic signed [7:0] GRAV_S     = 8'(GRAVITY);
    localparam logic signed [7:0] FALL_S     = 8'(-V_MAX_FALL);
    localparam logic signed [8:0] MAX_H_S    = 9'(MAX_H);
    localparam logic [7:0]        MAX_H_U    = 8'(MAX_H);
`ifdef TREX_VARIABLE_JUMP_EN
    localparam logic signed [6:0] CUT_VEL    = 7'(CUT_V);
`endif

    dinoState_e        state, stateNext;
    logic [7:0]        height, heightNext;
    logic signed [6:0] vel, velNext, velWork;
    logic signed [8:0] sum;
    logic signed [7:0] velDec;
    logic              jumpPending, jumpRise, jumpReq;
    logic [8:0]        dinoYNext;
    logic [1:0]        poseNext;
    logic              airborneNext;

    rise_edge_pulse uJumpEdge (
        .clk   (clk),
        .rst   (rst),
        .level (jump),
        .pulse (jumpRise)
    );

    // An edge landing on the tick cycle itself is honoured by that tick.
    assign jumpReq = jumpPending | jumpRise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jumpPending <= 1'b0;
        end else if (frame_tick) begin
            jumpPending <= 1'b0;
        end else if (jumpRise) begin
            jumpPending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_GROUND;
            height   <= '0;
            vel      <= '0;
            dino_y   <= GROUND_Y_U;
            pose     <= POSE_STAND;
            airborne <= 1'b0;
        end else if (frame_tick) begin
            state    <= stateNext;
            height   <= heightNext;
            vel      <= velNext;
            dino_y   <= dinoYNext;
            pose     <= poseNext;
            airborne <= airborneNext;
        end
    end

    always_comb begin
        stateNext  = state;
        heightNext = height;
        velNext    = vel;
        velWork    = vel;
        sum        = '0;
        velDec     = '0;

        if (isDead(game_state)) begin
            stateNext = ST_DEAD;
        end else begin
            case (state)
                ST_GROUND: begin
                    if (jumpReq && (game_state == GS_IDLE || game_state == GS_RUN)) begin
                        stateNext = ST_AIR;
                        velNext   = JUMP_VEL;
                    end else if (duck && game_state == GS_RUN) begin
                        stateNext = ST_DUCK;
                    end
                end
                ST_DUCK: begin
                    if (jumpReq) begin
                        stateNext = ST_AIR;
                        velNext   = JUMP_VEL;
                    end else if (!duck) begin
                        stateNext = ST_GROUND;
                    end
                end
                ST_AIR: begin
`ifdef TREX_VARIABLE_JUMP_EN
                    if (!jump && velWork > CUT_VEL) begin
                        velWork = CUT_VEL;
                    end
`endif
                    sum = $signed({1'b0, height}) + $signed({{2{velWork[6]}}, velWork});
                    // Landing wins outright and skips gravity for this tick.
                    if (sum <= 9'sd0) begin
                        stateNext  = ST_GROUND;
                        heightNext = '0;
                        velNext    = '0;
                    end else begin
                        if (sum > MAX_H_S) begin
                            heightNext = MAX_H_U;
                            velWork    = '0;
                        end else begin
                            heightNext = sum[7:0];
                        end
                        velDec = $signed({velWork[6], velWork}) - GRAV_S;
                        if (velDec < FALL_S) begin
                            velNext = FALL_S[6:0];
                        end else begin
                            velNext = velDec[6:0];
                        end
                    end
                end
                ST_DEAD: begin
                    if (game_state == GS_IDLE) begin
                        stateNext  = ST_GROUND;
                        heightNext = '0;
                        velNext    = '0;
                    end
                end
                default: begin
                    stateNext = ST_GROUND;
                end
            endcase
        end
    end

    always_comb begin
        dinoYNext    = GROUND_Y_U - {1'b0, heightNext};
        airborneNext = (heightNext != 8'd0) || (velNext != 7'sd0);
        case (stateNext)
            ST_AIR:  poseNext = POSE_AIR;
            ST_DUCK: poseNext = POSE_DUCK;
            ST_DEAD: poseNext = POSE_DEAD;
            default: poseNext = POSE_STAND;
        endcase
    end

endmodule

// File: tb/tb_dino_jump_physics.sv
// Randomized self-checking bench: default instance plus a MAX_H=50 instance against a frame-level model.
module tb_dino_jump_physics;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       jump;
    logic       duck;
    logic [1:0] game_state;
    logic [8:0] dinoYA, dinoYB;
    logic [1:0] poseA, poseB;
    logic       airA, airB;

    int checkCount = 0;
    int errorCount = 0;

    int mH[2];
    int mV[2];
    bit mAir[2];
    bit mDuck[2];
    bit mDead[2];
    int maxH[2] = '{200, 50};
    bit mPending;
    bit lastJump;
    int minYB;

    always #5 clk = ~clk;

    dino_jump_physics uDutA (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .jump       (jump),
        .duck       (duck),
        .game_state (game_state),
        .dino_y     (dinoYA),
        .pose       (poseA),
        .airborne   (airA)
    );

    dino_jump_physics #(.MAX_H(50)) uDutB (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .jump       (jump),
        .duck       (duck),
        .game_state (game_state),
        .dino_y     (dinoYB),
        .pose       (poseB),
        .airborne   (airB)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mH[i] = 0; mV[i] = 0; mAir[i] = 0; mDuck[i] = 0; mDead[i] = 0;
        end
        mPending = 0;
    endtask

    // One frame of game rules applied to both model instances.
    task automatic modelTick();
        for (int i = 0; i < 2; i++) begin
            int s;
            if (game_state[0]) begin
                mDead[i] = 1; mAir[i] = 0; mDuck[i] = 0;
            end else if (mDead[i]) begin
                if (game_state == 2'b00) begin
                    mDead[i] = 0; mH[i] = 0; mV[i] = 0;
                end
            end else if (mAir[i]) begin
`ifdef TREX_VARIABLE_JUMP_EN
                if (!jump && mV[i] > 4) mV[i] = 4;
`endif
                s = mH[i] + mV[i];
                if (s <= 0) begin
                    mH[i] = 0; mV[i] = 0; mAir[i] = 0;
                end else begin
                    if (s > maxH[i]) begin
                        mH[i] = maxH[i]; mV[i] = 0;
                    end else begin
                        mH[i] = s;
                    end
                    mV[i] = (mV[i] - 1 < -20) ? -20 : mV[i] - 1;
                end
            end else if (mPending) begin
                mAir[i] = 1; mDuck[i] = 0; mV[i] = 14;
            end else if (mDuck[i]) begin
                if (!duck) mDuck[i] = 0;
            end else if (duck && game_state == 2'b10) begin
                mDuck[i] = 1;
            end
        end
        mPending = 0;
    endtask

    task automatic checkAgainstModel();
        int expPose[2];
        for (int i = 0; i < 2; i++) begin
            expPose[i] = mDead[i] ? 3 : mAir[i] ? 2 : mDuck[i] ? 1 : 0;
        end
        checkOutput("dinoY_A", int'(dinoYA), 360 - mH[0]);
        checkOutput("pose_A", int'(poseA), expPose[0]);
        checkOutput("airborne_A", int'(airA), int'(mH[0] != 0 || mV[0] != 0));
        checkOutput("dinoY_B", int'(dinoYB), 360 - mH[1]);
        checkOutput("pose_B", int'(poseB), expPose[1]);
        checkOutput("airborne_B", int'(airB), int'(mH[1] != 0 || mV[1] != 0));
    endtask

    task automatic setJump(input bit level);
        if (level && !lastJump) mPending = 1;
        lastJump = level;
        jump = level;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse frame_tick for one cycle, then compare the registered outputs.
    task automatic applyStimulus();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        modelTick();
        checkAgainstModel();
        if (int'(dinoYB) < minYB) minYB = int'(dinoYB);
    endtask

    task automatic jumpEdge();
        if (lastJump) begin
            setJump(0);
            idleCycles(1);
        end
        setJump(1);
    endtask

    initial begin
        int r;
        rst = 1'b0; frame_tick = 1'b0; jump = 1'b0; duck = 1'b0;
        game_state = 2'b10; lastJump = 0;
        modelReset();
        idleCycles(3);
        checkOutput("reset_dinoY", int'(dinoYA), 360);
        checkOutput("reset_pose", int'(poseA), 0);
        checkOutput("reset_airborne", int'(airA), 0);
        rst = 1'b1;
        idleCycles(2);

        // Edge arrives and is released between ticks; the pending latch must still launch.
        minYB = 360;
        setJump(1);
        idleCycles(2);
        setJump(0);
        idleCycles(2);
        applyStimulus();
        checkOutput("launch_pose", int'(poseA), 2);
        for (int t = 2; t <= 30; t++) begin
            applyStimulus();
            if (t == 15 || t == 16) checkOutput("apex_dinoY", int'(dinoYA), 255);
            if (t == 29) checkOutput("preland_airborne", int'(airA), 1);
        end
        checkOutput("land_dinoY", int'(dinoYA), 360);
        checkOutput("land_pose", int'(poseA), 0);
        checkOutput("land_airborne", int'(airA), 0);
        checkOutput("ceiling_minY_B", minYB, 310);

        // Duck then jump with duck still held.
        duck = 1'b1;
        applyStimulus();
        checkOutput("duck_pose", int'(poseA), 1);
        jumpEdge();
        applyStimulus();
        checkOutput("duckjump_pose", int'(poseA), 2);
        setJump(0);
        applyStimulus();
        checkOutput("duckjump_v0", int'(dinoYA), 346);
        duck = 1'b0;
        repeat (30) applyStimulus();

        // Death mid-air freezes height, idle restarts on the ground.
        jumpEdge();
        applyStimulus();
        setJump(0);
        repeat (5) applyStimulus();
        checkOutput("predead_dinoY", int'(dinoYA), 300);
        game_state = 2'b01;
        repeat (10) begin
            applyStimulus();
            checkOutput("dead_dinoY", int'(dinoYA), 300);
            checkOutput("dead_pose", int'(poseA), 3);
        end
        game_state = 2'b00;
        applyStimulus();
        checkOutput("restart_dinoY", int'(dinoYA), 360);
        checkOutput("restart_pose", int'(poseA), 0);
        game_state = 2'b10;

        // Asynchronous reset mid-jump.
        jumpEdge();
        applyStimulus();
        setJump(0);
        repeat (3) applyStimulus();
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_dinoY", int'(dinoYA), 360);
        checkOutput("async_rst_pose", int'(poseA), 0);
        checkOutput("async_rst_airborne", int'(airA), 0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        idleCycles(1);

        // Randomized play.
        for (int n = 0; n < 300; n++) begin
            if (game_state[0]) begin
                r = $urandom_range(0, 9);
                if (r >= 9) game_state = 2'b10;
                else if (r >= 5) game_state = 2'b00;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 4) game_state = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
                else if (r < 12) game_state = 2'b00;
                else game_state = 2'b10;
            end
            duck = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 99);
            if (r < 30) begin
                jumpEdge();
                if ($urandom_range(0, 2) != 0) begin
                    idleCycles(1 + $urandom_range(0, 1));
                    if ($urandom_range(0, 1) == 0) setJump(0);
                end
            end else if (r < 45) begin
                setJump(0);
                idleCycles(1);
            end
            idleCycles($urandom_range(0, 2));
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
